// File: rtl/prod_unit_n.sv
// Serial product unit: ID, MQ and PN recirculating lines driven by a command FSM
// locked to line revolutions (load, read, clear and shift-and-add multiply).
module prod_unit_n #(
   parameter  int WORD_BITS  = 29,
   parameter  int PREC_WORDS = 2,
   localparam int LINE_BITS  = WORD_BITS * PREC_WORDS,
   localparam int CNT_W      = $clog2(LINE_BITS + 1)
) (
   input  logic             CLOCK,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [1:0]       cmd_sel,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic             abort,
   input  logic             lb_in,
   output logic             eb_out,
   output logic             eb_valid,
   output logic             line_start,
   output logic             busy,
   output logic             done,
   output logic             ovf
);

   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_READ  = 3'b001;
   localparam logic [2:0] OP_CLEAR = 3'b010;
   localparam logic [2:0] OP_MUL   = 3'b011;

   localparam logic [1:0] SEL_ID  = 2'd0;
   localparam logic [1:0] SEL_MQ  = 2'd1;
   localparam logic [1:0] SEL_PN  = 2'd2;
   localparam logic [1:0] SEL_ALL = 2'd3;

   localparam logic [CNT_W-1:0] TB_LAST  = CNT_W'(LINE_BITS - 1);
   localparam logic [CNT_W-1:0] MAX_STEP = CNT_W'(LINE_BITS);

   typedef enum logic [1:0] {IDLE, WAIT, EXEC, FIN} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     tb_q;
   logic [CNT_W-1:0]     rem_q;
   logic [2:0]           op_q;
   logic [1:0]           sel_q;
   logic                 abort_q;
   logic [LINE_BITS-1:0] id_q, mq_q, pn_q;
   logic                 ovf_q;

   logic                 accept, exec, rev_end, last_rev, mul_step, clr_ovf;
   logic                 wr_id, wr_mq, wr_pn, wr_bit;
   logic [LINE_BITS:0]   sum;

   assign cmd_ready  = (state_q == IDLE) || (state_q == FIN);
   assign accept     = cmd_valid && cmd_ready;
   assign exec       = (state_q == EXEC);
   assign rev_end    = (tb_q == TB_LAST);
   assign line_start = (tb_q == '0);
   assign busy       = (state_q == WAIT) || exec;
   assign done       = (state_q == FIN);
   assign ovf        = ovf_q;

   // A MUL with no steps left (n=0) still spends its one revolution, just without changes.
   assign mul_step = exec && rev_end && (op_q == OP_MUL) && (rem_q != '0);
   assign last_rev = (op_q != OP_MUL) || (rem_q <= CNT_W'(1)) || abort_q || abort;
   assign clr_ovf  = exec && rev_end && (op_q == OP_CLEAR) &&
                     ((sel_q == SEL_PN) || (sel_q == SEL_ALL));
   assign sum      = {1'b0, pn_q} + {1'b0, id_q};

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      wr_id  = 1'b0;
      wr_mq  = 1'b0;
      wr_pn  = 1'b0;
      wr_bit = (op_q == OP_LOAD) ? lb_in : 1'b0;
      if (exec && (op_q == OP_LOAD)) begin
         wr_id = (sel_q == SEL_ID);
         wr_mq = (sel_q == SEL_MQ);
         wr_pn = (sel_q == SEL_PN);
      end else if (exec && (op_q == OP_CLEAR)) begin
         wr_id = (sel_q == SEL_ID) || (sel_q == SEL_ALL);
         wr_mq = (sel_q == SEL_MQ) || (sel_q == SEL_ALL);
         wr_pn = (sel_q == SEL_PN) || (sel_q == SEL_ALL);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         // Accepting on the last bit time leaves nothing to wait for.
         IDLE:    if (accept) state_d = rev_end ? EXEC : WAIT;
         WAIT:    if (rev_end) state_d = EXEC;
         EXEC:    if (rev_end && last_rev) state_d = FIN;
         FIN:     state_d = accept ? WAIT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      eb_out   = 1'b0;
      eb_valid = 1'b0;
      if (exec && (op_q == OP_READ)) begin
         case (sel_q)
            SEL_ID:  begin eb_valid = 1'b1; eb_out = id_q[tb_q]; end
            SEL_MQ:  begin eb_valid = 1'b1; eb_out = mq_q[tb_q]; end
            SEL_PN:  begin eb_valid = 1'b1; eb_out = pn_q[tb_q]; end
            default: ;
         endcase
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge CLOCK) begin
      if (rst) begin
         state_q <= IDLE;
         tb_q    <= '0;
         rem_q   <= '0;
         op_q    <= OP_LOAD;
         sel_q   <= SEL_ID;
         abort_q <= 1'b0;
         id_q    <= '0;
         mq_q    <= '0;
         pn_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tb_q    <= rev_end ? '0 : tb_q + 1'b1;
         if (accept) begin
            op_q    <= cmd_op;
            sel_q   <= cmd_sel;
            abort_q <= 1'b0;
            rem_q   <= (cmd_cnt > MAX_STEP) ? MAX_STEP : cmd_cnt;
         end
         if (exec && (op_q == OP_MUL) && abort) abort_q <= 1'b1;
         if (wr_id) id_q[tb_q] <= wr_bit;
         if (wr_mq) mq_q[tb_q] <= wr_bit;
         if (wr_pn) pn_q[tb_q] <= wr_bit;
         if (clr_ovf) ovf_q <= 1'b0;
         // The whole step lands on the revolution boundary, which keeps it atomic under abort.
         if (mul_step) begin
            rem_q <= rem_q - 1'b1;
            id_q  <= id_q << 1;
            mq_q  <= mq_q >> 1;
            if (mq_q[0]) begin
               pn_q  <= sum[LINE_BITS-1:0];
               ovf_q <= ovf_q | sum[LINE_BITS];
            end
         end
      end
   end

endmodule

// File: tb/tb_prod_unit_n.sv
// Scoreboard bench for prod_unit_n: the driver queues hand-computed expectations,
// the monitor pops one per done pulse and checks latency, flags and READ streams.
module tb_prod_unit_n;

   localparam int LB = 58;
   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_READ  = 3'b001;
   localparam logic [2:0] OP_CLEAR = 3'b010;
   localparam logic [2:0] OP_MUL   = 3'b011;
   localparam logic [2:0] OP_NOP   = 3'b111;
   localparam logic [LB-1:0] ALT   = 58'h155_5555_5555_5555;
   localparam logic [LB-1:0] ONES  = {LB{1'b1}};
   localparam logic [LB-1:0] TOP   = 58'd1 << 57;
   localparam logic [LB-1:0] MQ_55 = (58'd1 << 55) - 58'd1;
   localparam logic [LB-1:0] MQ_53 = (58'd1 << 53) - 58'd1;

   typedef struct {
      string         name;
      int            exp_done;
      logic          exp_ovf;
      logic          is_read;
      logic [LB-1:0] rd_exp;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'b000;
   logic [1:0] cmd_sel = 2'd0;
   logic [5:0] cmd_cnt = 6'd0;
   logic       abort = 1'b0;
   logic       lb_in = 1'b0;
   logic       eb_out, eb_valid, line_start, busy, done, ovf;

   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            tb_m = 0;
   exp_t          sb[$];
   logic          ovf_exp = 1'b0;
   int            last_acc_cyc = 0;
   int            last_tb_a = 0;
   logic [LB-1:0] lb_src = '0;
   logic [LB-1:0] rd_acc = '0;
   int            rd_cnt = 0;
   int            eb_stray = 0;

   prod_unit_n #(.WORD_BITS(29), .PREC_WORDS(2)) dut (
      .CLOCK(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_cnt(cmd_cnt), .abort(abort),
      .lb_in(lb_in), .eb_out(eb_out), .eb_valid(eb_valid), .line_start(line_start),
      .busy(busy), .done(done), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Independent bit-time model, used to time stimulus and predict latency.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) tb_m <= 0;
      else     tb_m <= (tb_m == LB - 1) ? 0 : tb_m + 1;
   end

   always @(negedge clk) lb_in = lb_src[tb_m];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t rec;
      if (rst) begin
         rd_acc   = '0;
         rd_cnt   = 0;
         eb_stray = 0;
      end else begin
         if (eb_valid) begin
            if (rd_cnt < LB) rd_acc[rd_cnt] = eb_out;
            rd_cnt++;
         end else if (eb_out !== 1'b0) begin
            eb_stray++;
         end
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 64'(done), 64'd0);
            end else begin
               rec = sb.pop_front();
               check({rec.name, "_done_cycle"}, 64'(cyc), 64'(rec.exp_done));
               check({rec.name, "_line_start"}, 64'(line_start), 64'd1);
               check({rec.name, "_ready_at_done"}, 64'(cmd_ready), 64'd1);
               check({rec.name, "_busy_at_done"}, 64'(busy), 64'd0);
               check({rec.name, "_ovf"}, 64'(ovf), 64'(rec.exp_ovf));
               check({rec.name, "_eb_stray"}, 64'(eb_stray), 64'd0);
               check({rec.name, "_eb_valid_cycles"}, 64'(rd_cnt), rec.is_read ? 64'd58 : 64'd0);
               if (rec.is_read) check({rec.name, "_data"}, 64'(rd_acc), 64'(rec.rd_exp));
            end
            rd_acc   = '0;
            rd_cnt   = 0;
            eb_stray = 0;
         end
      end
   end

   task automatic push_rec(input string name, input int exp_done, input logic is_read,
                           input logic [LB-1:0] rd_exp);
      exp_t rec;
      rec.name     = name;
      rec.exp_done = exp_done;
      rec.exp_ovf  = ovf_exp;
      rec.is_read  = is_read;
      rec.rd_exp   = rd_exp;
      sb.push_back(rec);
   endtask

   // Offers one command (optionally at a chosen bit time) and queues its expectation.
   task automatic issue(input string name, input logic [2:0] op, input logic [1:0] sel,
                        input logic [5:0] cnt, input int revs, input logic is_read,
                        input logic [LB-1:0] rd_exp, input int at_tb);
      int guard = 0;
      @(negedge clk);
      while (!(cmd_ready && (at_tb < 0 || tb_m == at_tb)) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         check({name, "_ready_timeout"}, 64'(cmd_ready), 64'd1);
         return;
      end
      cmd_op       = op;
      cmd_sel      = sel;
      cmd_cnt      = cnt;
      cmd_valid    = 1'b1;
      last_acc_cyc = cyc;
      last_tb_a    = tb_m;
      push_rec(name, cyc + (LB - tb_m) + revs * LB, is_read, rd_exp);
      @(negedge clk);
      cmd_valid = 1'b0;
      check({name, "_ready_low"}, 64'(cmd_ready), 64'd0);
      check({name, "_busy"}, 64'(busy), 64'd1);
   endtask

   task automatic drain(input string name);
      int guard = 0;
      while (sb.size() != 0 && guard < 4000) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         check({name, "_drain_timeout"}, 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   task automatic run(input string name, input logic [2:0] op, input logic [1:0] sel,
                      input logic [5:0] cnt, input int revs);
      issue(name, op, sel, cnt, revs, 1'b0, '0, -1);
      drain(name);
   endtask

   task automatic ld(input string name, input logic [1:0] sel, input logic [LB-1:0] val);
      lb_src = val;
      run(name, OP_LOAD, sel, 6'd0, 1);
   endtask

   task automatic rd(input string name, input logic [1:0] sel, input logic [LB-1:0] exp);
      issue(name, OP_READ, sel, 6'd0, 1, 1'b1, exp, -1);
      drain(name);
   endtask

   task automatic wait_cyc(input int target);
      int guard = 0;
      while (cyc < target && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached with %0d entries pending", sb.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ls_bad;
      int first_done;
      int guard;
      int exec_start;
      int done_seen;

      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_eb_valid", 64'(eb_valid), 64'd0);
      check("rst_eb_out", 64'(eb_out), 64'd0);
      check("rst_line_start", 64'(line_start), 64'd1);
      check("rst_ovf", 64'(ovf), 64'd0);
      rst = 1'b0;

      ls_bad = 0;
      repeat (120) begin
         @(negedge clk);
         if (line_start !== (tb_m == 0)) ls_bad++;
      end
      check("line_start_period", 64'(ls_bad), 64'd0);

      // Alternating serial load, read back as a stream.
      ld("load_alt", 2'd0, ALT);
      rd("read_alt", 2'd0, ALT);

      // 5 x 3 over a full 58-step multiply.
      ld("load_id5", 2'd0, 58'd5);
      ld("load_mq3", 2'd1, 58'd3);
      run("clear_pn", OP_CLEAR, 2'd2, 6'd0, 1);
      run("mul58", OP_MUL, 2'd0, 6'd58, 58);
      rd("read_pn15", 2'd2, 58'd15);
      rd("read_id_shifted_out", 2'd0, 58'd0);
      rd("read_mq_shifted_out", 2'd1, 58'd0);
      ld("load_all_is_nop", 2'd3, ONES);
      rd("read_id_after_nop_load", 2'd0, 58'd0);

      // Carry out of the top bit sets ovf; clearing PN drops it.
      ld("load_pn_top", 2'd2, TOP);
      ld("load_id_top", 2'd0, TOP);
      ld("load_mq1", 2'd1, 58'd1);
      ovf_exp = 1'b1;
      run("mul1_ovf", OP_MUL, 2'd0, 6'd1, 1);
      rd("read_pn_wrapped", 2'd2, 58'd0);
      rd("read_id_msb_dropped", 2'd0, 58'd0);
      ovf_exp = 1'b0;
      run("clear_pn_ovf", OP_CLEAR, 2'd2, 6'd0, 1);

      // Abort raised mid step 3 finishes that step and stops.
      ld("load_id1", 2'd0, 58'd1);
      ld("load_mq_ones", 2'd1, ONES);
      run("clear_pn2", OP_CLEAR, 2'd2, 6'd0, 1);
      issue("mul_abort", OP_MUL, 2'd0, 6'd58, 3, 1'b0, '0, -1);
      exec_start = last_acc_cyc + (LB - last_tb_a);
      wait_cyc(exec_start + 2 * LB + 20);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      drain("mul_abort");
      rd("read_pn7", 2'd2, 58'd7);
      rd("read_id8", 2'd0, 58'd8);
      rd("read_mq55", 2'd1, MQ_55);

      // Abort while still waiting for the line start is ignored.
      issue("mul2_abort_in_wait", OP_MUL, 2'd0, 6'd2, 2, 1'b0, '0, 5);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      drain("mul2_abort_in_wait");
      rd("read_pn31", 2'd2, 58'd31);

      // Last-bit-time accept: only one cycle before execution starts.
      issue("nop_at_tb57", OP_NOP, 2'd0, 6'd0, 1, 1'b0, '0, 57);
      drain("nop_at_tb57");

      // cmd_valid held high: the second command may only be taken in the done cycle.
      guard = 0;
      @(negedge clk);
      while (!(cmd_ready && tb_m == 20) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      cmd_op    = OP_NOP;
      cmd_sel   = 2'd0;
      cmd_cnt   = 6'd0;
      cmd_valid = 1'b1;
      first_done = cyc + (LB - 20) + LB;
      push_rec("hold_nop", first_done, 1'b0, '0);
      @(negedge clk);
      cmd_op  = OP_MUL;
      cmd_cnt = 6'd0;
      guard = 0;
      while (!cmd_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("hold_second_accept_cycle", 64'(cyc), 64'(first_done));
      push_rec("hold_mul0", cyc + 2 * LB, 1'b0, '0);
      @(negedge clk);
      cmd_valid = 1'b0;
      drain("hold_mul0");
      rd("read_pn_unchanged", 2'd2, 58'd31);
      rd("read_id_unchanged", 2'd0, 58'd32);
      rd("read_mq_unchanged", 2'd1, MQ_53);

      // Step count above LINE_BITS clamps to 58; step 58 consumes MQ's top bit.
      run("clear_all", OP_CLEAR, 2'd3, 6'd0, 1);
      ld("load_id1b", 2'd0, 58'd1);
      ld("load_mq_top", 2'd1, TOP);
      run("mul63_clamped", OP_MUL, 2'd0, 6'd63, 58);
      rd("read_pn_top", 2'd2, TOP);
      rd("read_mq_empty", 2'd1, 58'd0);

      // Reset during step 10 of a multiply that has already set ovf.
      ld("load_pn_top2", 2'd2, TOP);
      ld("load_id_top2", 2'd0, TOP);
      ld("load_mq_ones2", 2'd1, ONES);
      issue("mul20_reset", OP_MUL, 2'd0, 6'd20, 20, 1'b0, '0, -1);
      exec_start = last_acc_cyc + (LB - last_tb_a);
      wait_cyc(exec_start + 9 * LB + 10);
      check("ovf_before_reset", 64'(ovf), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      sb.delete();
      check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("midrst_line_start", 64'(line_start), 64'd1);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_ovf", 64'(ovf), 64'd0);
      rst = 1'b0;
      done_seen = 0;
      repeat (12 * LB) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("midrst_no_done", 64'(done_seen), 64'd0);
      ovf_exp = 1'b0;
      rd("read_id_after_rst", 2'd0, 58'd0);
      rd("read_mq_after_rst", 2'd1, 58'd0);
      rd("read_pn_after_rst", 2'd2, 58'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
